// File: rtl/apu_noise_square.sv
// Pulse and noise tone channels in the style of the NES APU. Each channel has
// a timer, an envelope and a length counter, and drives a registered 4-bit volume sample.
module apu_noise_square #(
  parameter int unsigned CPU_DIV   = 1,
  parameter int unsigned QF_CYCLES = 7457
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sq_reg0,
  input  logic [7:0] sq_reg1,
  input  logic [7:0] sq_reg2,
  input  logic [7:0] sq_reg3,
  input  logic [7:0] noise_reg0,
  input  logic [7:0] noise_reg2,
  input  logic [7:0] noise_reg3,
  output logic [3:0] sq_out,
  output logic [3:0] noise_out
);

  localparam int unsigned DIV_W  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int unsigned QF_W   = (QF_CYCLES > 1) ? $clog2(QF_CYCLES) : 1;
  localparam int unsigned ST_W   = 11;
  localparam int unsigned NT_W   = 12;
  localparam int unsigned LFSR_W = 15;

  function automatic logic [7:0] len_lut(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
    endcase
    return v;
  endfunction

  // Reload value is the NTSC period minus one, since the timer counts through zero.
  function automatic logic [NT_W-1:0] noise_reload(input logic [3:0] idx);
    logic [NT_W-1:0] v;
    case (idx)
      4'd0:  v = 12'd3;    4'd1:  v = 12'd7;    4'd2:  v = 12'd15;   4'd3:  v = 12'd31;
      4'd4:  v = 12'd63;   4'd5:  v = 12'd95;   4'd6:  v = 12'd127;  4'd7:  v = 12'd159;
      4'd8:  v = 12'd201;  4'd9:  v = 12'd253;  4'd10: v = 12'd379;  4'd11: v = 12'd507;
      4'd12: v = 12'd761;  4'd13: v = 12'd1015; 4'd14: v = 12'd2033; default: v = 12'd4067;
    endcase
    return v;
  endfunction

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pat;
    case (duty)
      2'd0:    pat = 8'b0100_0000;
      2'd1:    pat = 8'b0110_0000;
      2'd2:    pat = 8'b0111_1000;
      default: pat = 8'b1001_1111;
    endcase
    return pat[3'd7 - step];
  endfunction

  // Quarter-frame envelope step; result packs {start, div, decay}.
  function automatic logic [8:0] env_step(input logic start, input logic [3:0] div,
                                          input logic [3:0] decay, input logic [3:0] period,
                                          input logic loop_en);
    logic [8:0] r;
    r = {start, div, decay};
    if (start) begin
      r = {1'b0, period, 4'd15};
    end else if (div == 4'd0) begin
      if (decay != 4'd0)  r = {1'b0, period, decay - 4'd1};
      else if (loop_en)   r = {1'b0, period, 4'd15};
      else                r = {1'b0, period, decay};
    end else begin
      r = {1'b0, div - 4'd1, decay};
    end
    return r;
  endfunction

  logic [DIV_W-1:0]  div_q, div_d;
  logic [QF_W-1:0]   qf_cnt_q, qf_cnt_d;
  logic              half_ph_q, half_ph_d;
  logic              apu_odd_q, apu_odd_d;
  logic              first_q, first_d;
  logic [7:0]        sq_reg3_prev_q, sq_reg3_prev_d;
  logic [7:0]        noise_reg3_prev_q, noise_reg3_prev_d;
  logic [ST_W-1:0]   sq_timer_q, sq_timer_d;
  logic [2:0]        sq_step_q, sq_step_d;
  logic [7:0]        sq_len_q, sq_len_d;
  logic              sq_env_start_q, sq_env_start_d;
  logic [3:0]        sq_env_div_q, sq_env_div_d;
  logic [3:0]        sq_decay_q, sq_decay_d;
  logic [NT_W-1:0]   noise_timer_q, noise_timer_d;
  logic [LFSR_W-1:0] noise_lfsr_q, noise_lfsr_d;
  logic [7:0]        noise_len_q, noise_len_d;
  logic              noise_env_start_q, noise_env_start_d;
  logic [3:0]        noise_env_div_q, noise_env_div_d;
  logic [3:0]        noise_decay_q, noise_decay_d;
  logic [3:0]        sq_out_q, sq_out_d;
  logic [3:0]        noise_out_q, noise_out_d;

  logic              cpu_tick_c, qf_tick_c, half_tick_c, sq_clk_c;
  logic              sq_load_c, noise_load_c;
  logic [ST_W-1:0]   sq_t_c;
  logic [3:0]        sq_vol_c, noise_vol_c;
  logic              noise_fb_c;
  logic              unused_c;

  assign unused_c = ^{sq_reg1, noise_reg0[7:6], noise_reg2[6:4]};

  assign cpu_tick_c   = (div_q == DIV_W'(CPU_DIV - 1));
  assign qf_tick_c    = cpu_tick_c && (qf_cnt_q == QF_W'(QF_CYCLES - 1));
  assign half_tick_c  = qf_tick_c && half_ph_q;
  assign sq_clk_c     = cpu_tick_c && apu_odd_q;
  assign sq_load_c    = first_q || (sq_reg3 != sq_reg3_prev_q);
  assign noise_load_c = first_q || (noise_reg3 != noise_reg3_prev_q);
  assign sq_t_c       = {sq_reg3[2:0], sq_reg2};
  assign sq_vol_c     = sq_reg0[4] ? sq_reg0[3:0] : sq_decay_q;
  assign noise_vol_c  = noise_reg0[4] ? noise_reg0[3:0] : noise_decay_q;
  assign noise_fb_c   = noise_lfsr_q[0] ^ (noise_reg2[7] ? noise_lfsr_q[6] : noise_lfsr_q[1]);

  always_comb begin
    div_d             = div_q;
    qf_cnt_d          = qf_cnt_q;
    half_ph_d         = half_ph_q;
    apu_odd_d         = apu_odd_q;
    first_d           = 1'b0;
    sq_reg3_prev_d    = sq_reg3;
    noise_reg3_prev_d = noise_reg3;
    sq_timer_d        = sq_timer_q;
    sq_step_d         = sq_step_q;
    sq_len_d          = sq_len_q;
    sq_env_start_d    = sq_env_start_q;
    sq_env_div_d      = sq_env_div_q;
    sq_decay_d        = sq_decay_q;
    noise_timer_d     = noise_timer_q;
    noise_lfsr_d      = noise_lfsr_q;
    noise_len_d       = noise_len_q;
    noise_env_start_d = noise_env_start_q;
    noise_env_div_d   = noise_env_div_q;
    noise_decay_d     = noise_decay_q;
    sq_out_d          = 4'd0;
    noise_out_d       = 4'd0;

    // CPU-cycle divider, frame sequencer and the APU half-rate phase
    div_d = cpu_tick_c ? '0 : div_q + DIV_W'(1);
    if (cpu_tick_c) begin
      apu_odd_d = ~apu_odd_q;
      qf_cnt_d  = qf_tick_c ? '0 : qf_cnt_q + QF_W'(1);
    end
    if (qf_tick_c) half_ph_d = ~half_ph_q;

    if (sq_clk_c) begin
      if (sq_timer_q == '0) begin
        sq_timer_d = sq_t_c;
        sq_step_d  = sq_step_q + 3'd1;
      end else begin
        sq_timer_d = sq_timer_q - ST_W'(1);
      end
    end

    if (cpu_tick_c) begin
      if (noise_timer_q == '0) begin
        noise_timer_d = noise_reload(noise_reg2[3:0]);
        noise_lfsr_d  = {noise_fb_c, noise_lfsr_q[LFSR_W-1:1]};
      end else begin
        noise_timer_d = noise_timer_q - NT_W'(1);
      end
    end

    if (qf_tick_c) begin
      {sq_env_start_d, sq_env_div_d, sq_decay_d} =
        env_step(sq_env_start_q, sq_env_div_q, sq_decay_q, sq_reg0[3:0], sq_reg0[5]);
      {noise_env_start_d, noise_env_div_d, noise_decay_d} =
        env_step(noise_env_start_q, noise_env_div_q, noise_decay_q, noise_reg0[3:0], noise_reg0[5]);
    end

    if (half_tick_c && sq_len_q != 8'd0 && !sq_reg0[5])       sq_len_d    = sq_len_q - 8'd1;
    if (half_tick_c && noise_len_q != 8'd0 && !noise_reg0[5]) noise_len_d = noise_len_q - 8'd1;

    // A load overrides any coincident frame-sequencer update of length and start flag
    if (sq_load_c) begin
      sq_len_d       = len_lut(sq_reg3[7:3]);
      sq_env_start_d = 1'b1;
      sq_step_d      = 3'd0;
    end
    if (noise_load_c) begin
      noise_len_d       = len_lut(noise_reg3[7:3]);
      noise_env_start_d = 1'b1;
    end

    if (duty_bit(sq_reg0[7:6], sq_step_q) && sq_len_q != 8'd0 && sq_t_c >= ST_W'(8))
      sq_out_d = sq_vol_c;
    if (!noise_lfsr_q[0] && noise_len_q != 8'd0)
      noise_out_d = noise_vol_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q             <= '0;
      qf_cnt_q          <= '0;
      half_ph_q         <= 1'b0;
      apu_odd_q         <= 1'b0;
      first_q           <= 1'b1;
      sq_reg3_prev_q    <= 8'd0;
      noise_reg3_prev_q <= 8'd0;
      sq_timer_q        <= '0;
      sq_step_q         <= 3'd0;
      sq_len_q          <= 8'd0;
      sq_env_start_q    <= 1'b0;
      sq_env_div_q      <= 4'd0;
      sq_decay_q        <= 4'd0;
      noise_timer_q     <= '0;
      noise_lfsr_q      <= LFSR_W'(1);
      noise_len_q       <= 8'd0;
      noise_env_start_q <= 1'b0;
      noise_env_div_q   <= 4'd0;
      noise_decay_q     <= 4'd0;
      sq_out_q          <= 4'd0;
      noise_out_q       <= 4'd0;
    end else begin
      div_q             <= div_d;
      qf_cnt_q          <= qf_cnt_d;
      half_ph_q         <= half_ph_d;
      apu_odd_q         <= apu_odd_d;
      first_q           <= first_d;
      sq_reg3_prev_q    <= sq_reg3_prev_d;
      noise_reg3_prev_q <= noise_reg3_prev_d;
      sq_timer_q        <= sq_timer_d;
      sq_step_q         <= sq_step_d;
      sq_len_q          <= sq_len_d;
      sq_env_start_q    <= sq_env_start_d;
      sq_env_div_q      <= sq_env_div_d;
      sq_decay_q        <= sq_decay_d;
      noise_timer_q     <= noise_timer_d;
      noise_lfsr_q      <= noise_lfsr_d;
      noise_len_q       <= noise_len_d;
      noise_env_start_q <= noise_env_start_d;
      noise_env_div_q   <= noise_env_div_d;
      noise_decay_q     <= noise_decay_d;
      sq_out_q          <= sq_out_d;
      noise_out_q       <= noise_out_d;
    end
  end

  assign sq_out    = sq_out_q;
  assign noise_out = noise_out_q;

endmodule

// File: tb/tb_apu_noise_square.sv
// Scoreboard bench for apu_noise_square: stimulus queues expected values tagged
// with the cycle they apply to; the monitor pops and compares them on the falling edge.
module tb_apu_noise_square;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sq_reg0 = 8'h00, sq_reg1 = 8'h00, sq_reg2 = 8'h00, sq_reg3 = 8'h00;
  logic [7:0] noise_reg0 = 8'h00, noise_reg2 = 8'h00, noise_reg3 = 8'h00;
  logic [3:0] sq_out, noise_out;

  apu_noise_square #(.CPU_DIV(1), .QF_CYCLES(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sq_reg0    (sq_reg0),
    .sq_reg1    (sq_reg1),
    .sq_reg2    (sq_reg2),
    .sq_reg3    (sq_reg3),
    .noise_reg0 (noise_reg0),
    .noise_reg2 (noise_reg2),
    .noise_reg3 (noise_reg3),
    .sq_out     (sq_out),
    .noise_out  (noise_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          kind;
    int unsigned exp;
  } item_t;

  item_t       sb[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned base  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(input int unsigned c, input int k, input int unsigned e);
    item_t it;
    it.cyc  = c;
    it.kind = k;
    it.exp  = e;
    sb.push_back(it);
  endfunction

  function automatic string kname(input int k);
    case (k)
      0:       return "sq_out";
      1:       return "noise_out";
      2:       return "lfsr";
      3:       return "noise_len";
      default: return "noise_decay";
    endcase
  endfunction

  function automatic int unsigned actual(input int k);
    case (k)
      0:       return int'(sq_out);
      1:       return int'(noise_out);
      2:       return int'(dut.noise_lfsr_q);
      3:       return int'(dut.noise_len_q);
      default: return int'(dut.noise_decay_q);
    endcase
  endfunction

  function automatic logic [14:0] lfsr_next(input logic [14:0] v, input logic mode);
    logic fb;
    fb = v[0] ^ (mode ? v[6] : v[1]);
    return {fb, v[14:1]};
  endfunction

  // Monitor: every expected item due at this cycle is compared and retired
  always @(negedge clk) begin
    int unsigned act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        total++;
        act = actual(sb[i].kind);
        if (sb[i].cyc < cyc) begin
          bad++;
          $display("FAIL %s late: due cyc %0d seen cyc %0d", kname(sb[i].kind), sb[i].cyc, cyc);
        end else if (act != sb[i].exp) begin
          bad++;
          $display("FAIL %s at rel cyc %0d: got %0d expected %0d",
                   kname(sb[i].kind), cyc - base, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [14:0] v;
    int unsigned e, d;
    int unsigned a_cyc[8] = '{50, 300, 700, 900, 1580, 1700, 1990, 2100};
    int unsigned a_val[8] = '{0,  15,  14,  0,   13,   12,   12,   0};

    // Phase A: square 50% duty with envelope decay, noise mode 0 at period 96
    sq_reg0 = 8'h84; sq_reg2 = 8'h60; sq_reg3 = 8'h00;
    noise_reg0 = 8'h01; noise_reg2 = 8'h05; noise_reg3 = 8'h00;
    repeat (3) @(posedge clk);
    release_reset();
    for (int i = 0; i < 8; i++) push(base + a_cyc[i], 0, a_val[i]);
    v = 15'h0001;
    for (int k = 0; k < 15; k++) begin
      v = lfsr_next(v, 1'b0);
      push(base + 50 + 96 * k, 2, int'(v));
      e = 59 + 96 * k;
      d = (e < 100) ? 0 : 15 - (e - 100) / 200;
      push(base + 60 + 96 * k, 1, v[0] ? 0 : d);
    end
    push(base + 2100, 1, 0);
    repeat (2110) @(negedge clk);

    // Phase B: square timer below 8 stays silent; noise mode 1 sequence and mid-run reload
    apply_reset();
    sq_reg0 = 8'hBF; sq_reg2 = 8'h05; sq_reg3 = 8'h00;
    noise_reg0 = 8'h00; noise_reg2 = 8'h80; noise_reg3 = 8'h00;
    release_reset();
    for (int i = 1; i < 8; i += 2) push(base + 100 * i, 0, 0);
    v = 15'h0001;
    for (int k = 0; k < 93; k++) begin
      v = lfsr_next(v, 1'b1);
      push(base + 2 + 4 * k, 2, int'(v));
    end
    push(base + 650, 4, 10);
    push(base + 650, 3, 7);
    push(base + 655, 3, 254);
    push(base + 655, 4, 10);
    push(base + 750, 4, 15);
    push(base + 750, 3, 254);
    push(base + 810, 3, 253);
    repeat (650) @(negedge clk);
    #1 noise_reg3 = 8'h08;
    repeat (170) @(negedge clk);

    // Phase C: constant-volume square, then reset asserted mid-run
    apply_reset();
    sq_reg0 = 8'hBF; sq_reg2 = 8'h60; sq_reg3 = 8'h00;
    noise_reg0 = 8'h1F; noise_reg2 = 8'h00; noise_reg3 = 8'h00;
    release_reset();
    push(base + 300, 0, 15);
    push(base + 400, 0, 15);
    repeat (400) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    push(cyc, 0, 0);
    push(cyc, 1, 0);
    push(cyc, 2, 1);
    repeat (3) @(posedge clk);
    release_reset();
    repeat (5) @(negedge clk);

    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s never checked: due cyc %0d expected %0d", kname(sb[i].kind), sb[i].cyc, sb[i].exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
